// File: rtl/data_memory_if.sv
// Execute-stage to data-memory request/response bundle.
// The error signal exists only when DMEM_BOUNDS_CHECK_EN is defined.
interface data_memory_if #(
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter int unsigned DATA_SIZE    = 32
);
    logic                    read;
    logic                    write;
    logic [ADDRESS_SIZE-1:0] address;
    logic [DATA_SIZE-1:0]    data_in;
    logic [DATA_SIZE-1:0]    data_out;
    logic                    busy;
    logic                    done;
    logic                    valid;
`ifdef DMEM_BOUNDS_CHECK_EN
    logic                    error;

    modport master (
        output read, write, address, data_in,
        input  data_out, busy, done, valid, error
    );
    modport slave (
        input  read, write, address, data_in,
        output data_out, busy, done, valid, error
    );
`else
    modport master (
        output read, write, address, data_in,
        input  data_out, busy, done, valid
    );
    modport slave (
        input  read, write, address, data_in,
        output data_out, busy, done, valid
    );
`endif
endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory serving one access at a time with WAIT_STATES extra cycles.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (out-of-range accesses flagged on error instead of wrapping).
module data_memory #(
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned WAIT_STATES  = 2
) (
    input  logic          clock,
    input  logic          reset,
    data_memory_if.slave  bus
);
    localparam int unsigned INDEX_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_BITS   = 4;
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK = 1'b1;
`else
    localparam bit BOUNDS_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_BITS-1:0]     cnt_q, cnt_d;
    logic [INDEX_BITS-1:0]   index_q;
    logic [DATA_SIZE-1:0]    wdata_q;
    logic                    wr_q;
    logic                    oob_q;

    logic                    accept;
    logic                    perform;
    logic                    req_oob;
    logic [INDEX_BITS-1:0]   acc_index;
    logic [DATA_SIZE-1:0]    acc_data;
    logic                    acc_write;
    logic                    acc_oob;
    logic                    mem_we;

    logic [DATA_SIZE-1:0]    mem [DEPTH];

    logic [DATA_SIZE-1:0]    data_out_q, data_out_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;

    // Extra top bit so DEPTH == 2**ADDRESS_SIZE still compares correctly
    assign req_oob = BOUNDS_CHECK &&
                     ({1'b0, bus.address} >= (ADDRESS_SIZE+1)'(DEPTH));

    // Access operands: straight from the bus when performed at acceptance, else latched
    always_comb begin
        acc_index = index_q;
        acc_data  = wdata_q;
        acc_write = wr_q;
        acc_oob   = oob_q;
        if (state_q == IDLE) begin
            acc_index = bus.address[INDEX_BITS-1:0];
            acc_data  = bus.data_in;
            acc_write = bus.write;
            acc_oob   = req_oob;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; write wins when read and write are both requested
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        perform = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.read || bus.write) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        perform = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_BITS'(WAIT_STATES);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_BITS'(1)) begin
                    perform = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered status and read data
    always_comb begin
        busy_d     = (state_d != IDLE);
        done_d     = perform;
        valid_d    = perform && !acc_write;
        data_out_d = data_out_q;
        if (valid_d) begin
            data_out_d = acc_oob ? '0 : mem[acc_index];
        end
    end

    // Request latch and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            index_q    <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            oob_q      <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            if (accept) begin
                index_q <= bus.address[INDEX_BITS-1:0];
                wdata_q <= bus.data_in;
                wr_q    <= bus.write;
                oob_q   <= req_oob;
            end
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
        end
    end

    // RAM is never cleared; reset gates the write so an aborted access cannot commit
    assign mem_we = reset && perform && acc_write && !acc_oob;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[acc_index] <= acc_data;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.valid    = valid_q;

`ifdef DMEM_BOUNDS_CHECK_EN
    logic error_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= perform && acc_oob;
        end
    end

    assign bus.error = error_q;
`endif
endmodule

// File: doc/data_memory.md
# data_memory

Data-memory responder for the Risky pipeline: the memory-side end of the `read`/`write`/`address`/data interface driven by the execute stage. It holds a word-addressed RAM and serves one access at a time. Each access takes a configurable number of wait states. It raises `busy` to stall the pipeline and pulses `done`/`valid` when the access completes. Read data is returned to the writeback stage for `WB_MEMORY` instructions.

## Interface
Parameters:
- `DEPTH`, 256: number of `DATA_SIZE`-bit words. Must be a power of two, ≤ 2^`ADDRESS_SIZE`.
- `WAIT_STATES`, 2: extra cycles per access, range 0..15.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `read` in 1: load request. Level, held until `done`.
- `write` in 1: store request. Level, held until `done`.
- `address` in `ADDRESS_SIZE`: word address.
- `data_in` in `DATA_SIZE`: store data, driven by the execute stage's `data_out`.
- `data_out` out `DATA_SIZE`: last completed read data, registered.
- `busy` out 1: access in progress, stall upstream.
- `done` out 1: one-cycle completion pulse, for reads and writes.
- `valid` out 1: one-cycle pulse, `data_out` updated by a read.
- `error` out 1: out-of-range access flag. Present only with `DMEM_BOUNDS_CHECK_EN`.

## Operation
- FSM states: `IDLE`, `WAIT`, `RESP`. A 4-bit wait counter `cnt`.
- `IDLE`, edge with `read|write`:
  - Latch address, data and op. If both `read` and `write` are high, the access is a write and `read` is ignored.
  - If `WAIT_STATES==0`, perform the access at this edge and go to `RESP`.
  - Otherwise set `cnt<=WAIT_STATES` and go to `WAIT`.
- `WAIT`, each edge:
  - If `cnt==1`, perform the access and go to `RESP`.
  - Otherwise `cnt<=cnt-1`.
- Performing the access:
  - Write: `mem[addr]<=latched data`.
  - Read: `data_out<=mem[addr]`.
- `RESP`: always goes to `IDLE` at the next edge. Inputs are ignored.
- Inputs are sampled only in `IDLE`. Changes to `read`, `write`, `address` or `data_in` in `WAIT`/`RESP` have no effect.
- Requester rule: after seeing `done`, the requester must drop `read`/`write` or present the next request in the following (`IDLE`) cycle. A still-high request there is accepted as a new access.
- `busy` = state≠`IDLE`, decoded from the state register (glitch-free).
- `done` = state==`RESP`. `valid` = state==`RESP` and latched op is read.
- `data_out` holds its value until the next read completes. Writes never change it.
- Address mapping: word index is `address[log2(DEPTH)-1:0]`.
- Reset:
  - State goes to `IDLE`, `cnt` to 0, latched request is cleared.
  - `data_out`=0, `busy`=0, `done`=0, `valid`=0, `error`=0.
  - RAM contents are not cleared.
  - Reset asserted during `WAIT` aborts the access: a pending write is not committed.

## Timing
- Acceptance edge N. The access is performed at edge N+W, where W=`WAIT_STATES`.
- `done`/`valid`/`data_out` are valid in the cycle after edge N+W, i.e. W+1 cycles after acceptance.
- `busy` is high for W+1 cycles, starting the cycle after acceptance.
- Back-to-back accesses are spaced at a minimum of W+2 cycles (acceptance to acceptance).
- Write-then-read to the same address: the read returns the new data.

## Configuration
- `DMEM_BOUNDS_CHECK_EN` defined:
  - The `error` port exists.
  - An access with `address >= DEPTH` suppresses the RAM write, and a read loads 0 into `data_out`.
  - `error` pulses high together with `done` (state `RESP`) for that access. `valid` still pulses for reads.
  - `error` is reset to 0.
- `DMEM_BOUNDS_CHECK_EN` undefined:
  - No `error` port.
  - Out-of-range addresses wrap modulo `DEPTH` and access the aliased word.

## Test plan
- W=2, `DEPTH`=256. Write 0x1234 to addr 5, then read addr 5:
  - Write: `busy` high for 3 cycles, `done` pulses.
  - Read: `valid`+`done` in the 3rd cycle after acceptance, `data_out`=0x1234.
- W=0. Back-to-back reads of addr 1 and addr 2, holding `read` continuously with the address changed right after `done`:
  - Each read completes 1 cycle after acceptance.
  - Acceptances are 2 cycles apart, and `data_out` follows mem[1] then mem[2].
- `read` and `write` high together with addr 7, data 0xAAAA:
  - Treated as a write. `valid` stays 0, `done` pulses, `data_out` is unchanged.
  - A later read of addr 7 returns 0xAAAA.
- Reset during `WAIT` of a write of 0x5555 to addr 9 (mem[9]=0x1111 beforehand):
  - All outputs go to 0 immediately.
  - A read after reset returns 0x1111.
- With `DMEM_BOUNDS_CHECK_EN` and `DEPTH`=16, write 0xBEEF to addr 20, then read addr 4:
  - The write pulses `error`. The read returns the old mem[4] with `error`=0.
- Without `DMEM_BOUNDS_CHECK_EN`, the same sequence: the read of addr 4 returns 0xBEEF.
